// File: rtl/ddr_bg_line_fetch.sv
// Line-buffered DDR background fetcher with ping-pong line buffers and a 2-cycle pixel path.
// Optional build macro BG_BLEND_EN averages background and pattern pixels on a hit.
module ddr_bg_line_fetch #(
  parameter int unsigned H_ACTIVE  = 800,
  parameter int unsigned V_ACTIVE  = 600,
  parameter logic [28:0] BASE_ADDR = 29'h0,
  parameter int unsigned BURST_LEN = 100
) (
  input  logic        clk_in,
  input  logic        resetb,
  input  logic [11:0] x_in,
  input  logic [11:0] y_in,
  input  logic        de_in,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic [7:0]  r_in,
  input  logic [7:0]  g_in,
  input  logic [7:0]  b_in,
  output logic [28:0] ddr_address,
  output logic [7:0]  ddr_burstcnt,
  output logic        ddr_read,
  input  logic        ddr_waitrequest,
  input  logic [63:0] ddr_readdata,
  input  logic        ddr_dataready,
  output logic [7:0]  r_out,
  output logic [7:0]  g_out,
  output logic [7:0]  b_out,
  output logic        de_out,
  output logic        hs_out,
  output logic        vs_out,
  output logic        underrun,
  output logic [1:0]  fsm_state_o
);

  localparam int unsigned WPL    = H_ACTIVE / 2;
  localparam int unsigned NBURST = WPL / BURST_LEN;
  localparam int unsigned DEPTH  = 2 * WPL;
  localparam int unsigned AW     = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  // Trigger detection
  logic        de_q, vs_q;
  logic        trig_v_q;
  logic [11:0] trig_line_q;
  logic        de_fall, vs_rise, vs_skip;
  logic [11:0] next_line;

  // Fill engine
  state_t      state_q;
  logic [11:0] line_q;
  logic        buf_q;
  logic [7:0]  burst_q;
  logic [7:0]  word_q;
  logic [AW-1:0] wr_ptr_q;
  logic        pend_v_q;
  logic [11:0] pend_line_q;
  logic [11:0] tag_q [2];
  logic [1:0]  ok_q;
  logic [28:0] addr_q;
  logic        read_q;
  logic        start_v;
  logic [11:0] start_line;
  logic        wr_en;

  // Line buffers and pixel pipeline
  logic [47:0] mem [DEPTH];
  logic [47:0] rd_q;
  logic [AW-1:0] rd_ptr;
  logic        hit;
  logic        s1_de_q, s1_hs_q, s1_vs_q, s1_hit_q, s1_odd_q;
  logic [23:0] s1_pat_q;
  logic [23:0] bg_pix;
  logic [23:0] pix_d, pix_q;
  logic        de_out_q, hs_out_q, vs_out_q;
  logic        underrun_q;
  logic        unused_bits;

  assign unused_bits = ^{ddr_readdata[63:56], ddr_readdata[31:24]};

  function automatic logic [28:0] line_addr(input logic [11:0] l);
    return BASE_ADDR + 29'(l) * 29'(WPL);
  endfunction

  assign de_fall   = de_q & ~de_in;
  assign vs_rise   = vs_in & ~vs_q;
  assign vs_skip   = (tag_q[0] == 12'd0) && ok_q[0];
  assign next_line = (y_in >= 12'(V_ACTIVE - 1)) ? 12'd0 : y_in + 12'd1;

  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      de_q        <= 1'b0;
      vs_q        <= 1'b0;
      trig_v_q    <= 1'b0;
      trig_line_q <= '0;
    end else begin
      de_q     <= de_in;
      vs_q     <= vs_in;
      trig_v_q <= 1'b0;
      if (vs_rise && !vs_skip) begin
        trig_v_q    <= 1'b1;
        trig_line_q <= 12'd0;
      end else if (de_fall) begin
        trig_v_q    <= 1'b1;
        trig_line_q <= next_line;
      end
    end
  end

  // A fresh trigger wins over an older pending one.
  assign start_v    = trig_v_q | pend_v_q;
  assign start_line = trig_v_q ? trig_line_q : pend_line_q;
  assign wr_en      = (state_q == S_DATA) && ddr_dataready;

  // Request handshake: ddr_read and ddr_address are held stable from the cycle
  // the request is raised until a cycle with ddr_waitrequest low accepts it.
  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      state_q     <= S_IDLE;
      line_q      <= '0;
      buf_q       <= 1'b0;
      burst_q     <= '0;
      word_q      <= '0;
      wr_ptr_q    <= '0;
      pend_v_q    <= 1'b0;
      pend_line_q <= '0;
      tag_q[0]    <= '0;
      tag_q[1]    <= '0;
      ok_q        <= '0;
      addr_q      <= '0;
      read_q      <= 1'b0;
    end else begin
      if (trig_v_q && state_q != S_IDLE) begin
        pend_v_q    <= 1'b1;
        pend_line_q <= trig_line_q;
      end
      case (state_q)
        S_IDLE: begin
          if (start_v) begin
            line_q              <= start_line;
            buf_q               <= start_line[0];
            burst_q             <= '0;
            word_q              <= '0;
            wr_ptr_q            <= start_line[0] ? AW'(WPL) : '0;
            ok_q[start_line[0]] <= 1'b0;
            addr_q              <= line_addr(start_line);
            read_q              <= 1'b1;
            pend_v_q            <= 1'b0;
            state_q             <= S_REQ;
          end
        end
        S_REQ: begin
          if (!ddr_waitrequest) begin
            read_q  <= 1'b0;
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (ddr_dataready) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
            if (word_q == 8'(BURST_LEN - 1)) begin
              word_q <= '0;
              if (burst_q == 8'(NBURST - 1)) begin
                tag_q[buf_q] <= line_q;
                ok_q[buf_q]  <= 1'b1;
                state_q      <= S_IDLE;
              end else begin
                burst_q <= burst_q + 8'd1;
                addr_q  <= addr_q + 29'(BURST_LEN);
                read_q  <= 1'b1;
                state_q <= S_REQ;
              end
            end else begin
              word_q <= word_q + 8'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Read-before-write: a same-cycle write to the read address returns old data.
  assign rd_ptr = (y_in[0] ? AW'(WPL) : AW'(0)) + AW'(x_in[11:1]);

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_ptr_q] <= {ddr_readdata[55:32], ddr_readdata[23:0]};
    if (de_in) rd_q <= mem[rd_ptr];
  end

  assign hit = de_in && ok_q[y_in[0]] && (tag_q[y_in[0]] == y_in);

  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      s1_de_q    <= 1'b0;
      s1_hs_q    <= 1'b0;
      s1_vs_q    <= 1'b0;
      s1_hit_q   <= 1'b0;
      s1_odd_q   <= 1'b0;
      s1_pat_q   <= '0;
      underrun_q <= 1'b0;
    end else begin
      s1_de_q  <= de_in;
      s1_hs_q  <= hs_in;
      s1_vs_q  <= vs_in;
      s1_hit_q <= hit;
      s1_odd_q <= x_in[0];
      s1_pat_q <= {r_in, g_in, b_in};
      if (de_in && !hit) underrun_q <= 1'b1;
    end
  end

  assign bg_pix = s1_odd_q ? rd_q[47:24] : rd_q[23:0];

`ifdef BG_BLEND_EN
  function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8:1];
  endfunction
`endif

  always_comb begin
    pix_d = '0;
    if (s1_de_q) begin
      if (s1_hit_q) begin
`ifdef BG_BLEND_EN
        pix_d = {avg8(bg_pix[23:16], s1_pat_q[23:16]),
                 avg8(bg_pix[15:8],  s1_pat_q[15:8]),
                 avg8(bg_pix[7:0],   s1_pat_q[7:0])};
`else
        pix_d = bg_pix;
`endif
      end else begin
        pix_d = s1_pat_q;
      end
    end
  end

  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      pix_q    <= '0;
      de_out_q <= 1'b0;
      hs_out_q <= 1'b0;
      vs_out_q <= 1'b0;
    end else begin
      pix_q    <= pix_d;
      de_out_q <= s1_de_q;
      hs_out_q <= s1_hs_q;
      vs_out_q <= s1_vs_q;
    end
  end

  assign r_out        = pix_q[23:16];
  assign g_out        = pix_q[15:8];
  assign b_out        = pix_q[7:0];
  assign de_out       = de_out_q;
  assign hs_out       = hs_out_q;
  assign vs_out       = vs_out_q;
  assign underrun     = underrun_q;
  assign ddr_address  = addr_q;
  assign ddr_read     = read_q;
  assign ddr_burstcnt = 8'(BURST_LEN);
  assign fsm_state_o  = state_q;

endmodule
